// File: rtl/light_mode_sequencer_if.sv
// Button/command bundle between the board-facing driver and light_mode_sequencer.
// Optional i_hold signal exists only when LIGHT_SEQ_HOLD_EN is defined.
interface light_mode_sequencer_if;
   logic       i_btnNext;
   logic       i_btnOff;
   logic       i_autoEn;
`ifdef LIGHT_SEQ_HOLD_EN
   logic       i_hold;
`endif
   logic [1:0] o_OnOffSW;
   logic       o_cmdStb;
   logic       o_auto;

`ifdef LIGHT_SEQ_HOLD_EN
   modport master (output i_btnNext, output i_btnOff, output i_autoEn, output i_hold,
                   input  o_OnOffSW, input o_cmdStb, input o_auto);
   modport slave  (input  i_btnNext, input i_btnOff, input i_autoEn, input i_hold,
                   output o_OnOffSW, output o_cmdStb, output o_auto);
`else
   modport master (output i_btnNext, output i_btnOff, output i_autoEn,
                   input  o_OnOffSW, input o_cmdStb, input o_auto);
   modport slave  (input  i_btnNext, input i_btnOff, input i_autoEn,
                   output o_OnOffSW, output o_cmdStb, output o_auto);
`endif
endinterface

// File: rtl/light_mode_sequencer.sv
// Light FSM command source: debounces Next/Off buttons, sequences 00->01->10->00
// manually or on a dwell timer in auto mode.
// Optional feature macro: LIGHT_SEQ_HOLD_EN (adds i_hold, freezes the dwell timer).
module light_mode_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned DWELL_CYCLES    = 100_000_000,
   parameter int unsigned CNT_W           = 27
) (
   input logic                   i_clk,
   input logic                   i_reset,
   light_mode_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);

   typedef enum logic {MANUAL, AUTO} state_t;

   state_t           state;
   logic [1:0]       btn_s1, btn_s2;      // bit0 = next, bit1 = off
   logic             auto_s1, auto_s2;
   logic             hold_s;
   logic [1:0]       btn_db, btn_db_d;
   logic [CNT_W-1:0] btn_cnt [2];
   logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
   logic [1:0]       cmd_q, cmd_nxt, succ;
   logic             stb_q, auto_q;
   logic             next_press, off_press, dwell_run;

   // Two-flop synchronizers for the asynchronous button and mode inputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         btn_s1  <= '0;
         btn_s2  <= '0;
         auto_s1 <= 1'b0;
         auto_s2 <= 1'b0;
      end else begin
         btn_s1  <= {bus.i_btnOff, bus.i_btnNext};
         btn_s2  <= btn_s1;
         auto_s1 <= bus.i_autoEn;
         auto_s2 <= auto_s1;
      end
   end

`ifdef LIGHT_SEQ_HOLD_EN
   logic [1:0] hold_sync;

   // Synchronizer for the dwell-freeze input.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) hold_sync <= '0;
      else         hold_sync <= {hold_sync[0], bus.i_hold};
   end
   assign hold_s = hold_sync[1];
`else
   assign hold_s = 1'b0;
`endif

   // Debounce: level follows the synced input only after an unbroken run of mismatches.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         btn_db     <= '0;
         btn_db_d   <= '0;
         btn_cnt[0] <= '0;
         btn_cnt[1] <= '0;
      end else begin
         btn_db_d <= btn_db;
         for (int unsigned i = 0; i < 2; i++) begin
            if (btn_s2[i] != btn_db[i]) begin
               if (btn_cnt[i] == DEB_MAX) begin
                  btn_db[i]  <= btn_s2[i];
                  btn_cnt[i] <= '0;
               end else begin
                  btn_cnt[i] <= btn_cnt[i] + 1'b1;
               end
            end else begin
               btn_cnt[i] <= '0;
            end
         end
      end
   end

   assign next_press = btn_db[0] & ~btn_db_d[0];
   assign off_press  = btn_db[1] & ~btn_db_d[1];
   assign succ       = (cmd_q == 2'b10) ? 2'b00 : cmd_q + 2'b01;
   assign dwell_run  = (state == AUTO) && auto_s2;

   // Next command and dwell count: off > next > dwell expiry; a press always restarts the dwell.
   always_comb begin
      cmd_nxt   = cmd_q;
      dwell_nxt = '0;
      if (dwell_run) dwell_nxt = hold_s ? dwell_cnt : dwell_cnt + 1'b1;
      if (off_press) begin
         cmd_nxt   = 2'b00;
         dwell_nxt = '0;
      end else if (next_press) begin
         cmd_nxt   = succ;
         dwell_nxt = '0;
      end else if (dwell_run && !hold_s && dwell_cnt == DWELL_MAX) begin
         cmd_nxt   = succ;
         dwell_nxt = '0;
      end
   end

   // Mode FSM with registered command, strobe and auto-flag outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= MANUAL;
         cmd_q     <= 2'b00;
         stb_q     <= 1'b0;
         auto_q    <= 1'b0;
         dwell_cnt <= '0;
      end else begin
         cmd_q     <= cmd_nxt;
         stb_q     <= (cmd_nxt != cmd_q);
         dwell_cnt <= dwell_nxt;
         case (state)
            MANUAL: if (auto_s2) begin
               state  <= AUTO;
               auto_q <= 1'b1;
            end
            AUTO: if (!auto_s2) begin
               state  <= MANUAL;
               auto_q <= 1'b0;
            end
            default: begin
               state  <= MANUAL;
               auto_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_OnOffSW = cmd_q;
   assign bus.o_cmdStb  = stb_q;
   assign bus.o_auto    = auto_q;

endmodule

// File: tb/tb_light_mode_sequencer.sv
// Randomized bench for light_mode_sequencer against a cycle-level behavioural model.
// Define LIGHT_SEQ_HOLD_EN to also exercise the dwell-freeze input.
module tb_light_mode_sequencer;
   localparam int DEB   = 4;
   localparam int DWELL = 10;

   logic i_clk   = 1'b0;
   logic i_reset = 1'b1;

   light_mode_sequencer_if bus ();

   light_mode_sequencer #(
      .DEBOUNCE_CYCLES (DEB),
      .DWELL_CYCLES    (DWELL),
      .CNT_W           (8)
   ) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: raw samples seen two edges late, debounce as run lengths,
   // command as an index into the 3-entry sequence, dwell as elapsed cycles.
   bit [3:0] hist[$];          // {hold, auto, off, next}
   int       cmd, strobe, in_auto, elapsed;
   int       level[2], run[2];
   bit       pend[2];

   function automatic void model_reset();
      hist.delete();
      cmd = 0; strobe = 0; in_auto = 0; elapsed = 0;
      for (int b = 0; b < 2; b++) begin
         level[b] = 0; run[b] = 0; pend[b] = 1'b0;
      end
   endfunction

   function automatic void model_edge(input bit [3:0] raw);
      bit [3:0] seen;
      int       old;
      hist.push_back(raw);
      seen = (hist.size() > 2) ? hist.pop_front() : 4'b0000;
      old  = cmd;
      if (pend[1]) begin
         cmd = 0; elapsed = 0;
      end else if (pend[0]) begin
         cmd = (cmd + 1) % 3; elapsed = 0;
      end else if (in_auto != 0 && seen[2] && !seen[3]) begin
         elapsed++;
         if (elapsed == DWELL) begin
            cmd = (cmd + 1) % 3; elapsed = 0;
         end
      end
      strobe = (cmd != old) ? 1 : 0;
      if (in_auto == 0 && seen[2]) begin
         in_auto = 1; elapsed = 0;
      end else if (in_auto != 0 && !seen[2]) begin
         in_auto = 0; elapsed = 0;
      end
      for (int b = 0; b < 2; b++) begin
         pend[b] = 1'b0;
         if (int'(seen[b]) != level[b]) run[b]++;
         else run[b] = 0;
         if (run[b] == DEB) begin
            pend[b]  = seen[b];
            level[b] = seen[b];
            run[b]   = 0;
         end
      end
   endfunction

   function automatic bit hold_raw();
`ifdef LIGHT_SEQ_HOLD_EN
      return bus.i_hold;
`else
      return 1'b0;
`endif
   endfunction

   task automatic step();
      @(posedge i_clk);
      if (i_reset) model_reset();
      else model_edge({hold_raw(), bus.i_autoEn, bus.i_btnOff, bus.i_btnNext});
      #1;
      check_val("cmd",  bus.o_OnOffSW, cmd);
      check_val("stb",  bus.o_cmdStb,  strobe);
      check_val("auto", bus.o_auto,    in_auto);
   endtask

   bit tgt[4];
   int bnc[4];

   task automatic drive_inputs();
      bus.i_btnNext = (bnc[0] > 0) ? 1'($urandom) : tgt[0];
      bus.i_btnOff  = (bnc[1] > 0) ? 1'($urandom) : tgt[1];
      bus.i_autoEn  = tgt[2];
`ifdef LIGHT_SEQ_HOLD_EN
      bus.i_hold    = tgt[3];
`endif
      for (int k = 0; k < 4; k++) if (bnc[k] > 0) bnc[k]--;
   endtask

   task automatic random_phase(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         if ($urandom_range(0, 24) == 0)  begin tgt[0] = !tgt[0]; bnc[0] = $urandom_range(0, 7); end
         if ($urandom_range(0, 59) == 0)  begin tgt[1] = !tgt[1]; bnc[1] = $urandom_range(0, 7); end
         if ($urandom_range(0, 199) == 0) tgt[2] = !tgt[2];
         if ($urandom_range(0, 39) == 0)  tgt[3] = !tgt[3];
         if ($urandom_range(0, 149) == 0 && !tgt[0] && !tgt[1]) begin
            tgt[0] = 1'b1; tgt[1] = 1'b1; bnc[0] = 0; bnc[1] = 0;
         end
         drive_inputs();
         step();
      end
   endtask

   task automatic quiet(input int cycles);
      for (int k = 0; k < 4; k++) begin tgt[k] = 1'b0; bnc[k] = 0; end
      for (int c = 0; c < cycles; c++) begin
         drive_inputs();
         step();
      end
   endtask

   initial begin
      bus.i_btnNext = 1'b0;
      bus.i_btnOff  = 1'b0;
      bus.i_autoEn  = 1'b0;
`ifdef LIGHT_SEQ_HOLD_EN
      bus.i_hold    = 1'b0;
`endif
      for (int k = 0; k < 4; k++) begin tgt[k] = 1'b0; bnc[k] = 0; end
      model_reset();

      step();
      step();
      #2 i_reset = 1'b0;

      random_phase(2500);

      // Walk the command to 10 manually, then hit reset mid-cycle.
      quiet(20);
      for (int c = 0; c < 300 && bus.o_OnOffSW != 2'b10; c++) begin
         tgt[0] = ((c % 16) < 8);
         drive_inputs();
         step();
      end
      check_val("reach_10", bus.o_OnOffSW, 2);
      #2 i_reset = 1'b1;
      #1;
      check_val("rst_async_cmd",  bus.o_OnOffSW, 0);
      check_val("rst_async_stb",  bus.o_cmdStb,  0);
      check_val("rst_async_auto", bus.o_auto,    0);
      model_reset();
      for (int k = 0; k < 4; k++) begin tgt[k] = 1'b0; bnc[k] = 0; end
      drive_inputs();
      step();
      step();
      #2 i_reset = 1'b0;
      quiet(10);

      random_phase(1500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
